// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator tile sequencer: register map of the
// downstream accelerator, sequencer state encoding and timing defaults.
package accel_pkg;

  // Accelerator register byte offsets
  localparam logic [31:0] ACC_CTRL = 32'h0000_0020;
  localparam logic [31:0] ACC_A0   = 32'h0000_0028;
  localparam logic [31:0] ACC_A1   = 32'h0000_002C;
  localparam logic [31:0] ACC_A2   = 32'h0000_0030;
  localparam logic [31:0] ACC_B0   = 32'h0000_0034;
  localparam logic [31:0] ACC_B1   = 32'h0000_0038;
  localparam logic [31:0] ACC_B2   = 32'h0000_003C;
  localparam logic [31:0] ACC_B3   = 32'h0000_0000;
  localparam logic [31:0] ACC_C    = 32'h0000_0004;
  localparam logic [31:0] ACC_C2   = 32'h0000_0008;

  // Wait cycles between the last B write and the C read
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDK,
    ST_GO,
    ST_FETCH,
    ST_SETTLE,
    ST_RDC,
    ST_RDC2,
    ST_DONE
  } state_t;

  // FETCH sub-step k (1..4) writes the word read at k-1 into B(k-1)
  function automatic logic [31:0] b_reg_off(input logic [3:0] k);
    logic [31:0] off;
    case (k)
      4'd1:    off = ACC_B0;
      4'd2:    off = ACC_B1;
      4'd3:    off = ACC_B2;
      default: off = ACC_B3;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/accel_tile_agen.sv
// Tile address generator: tracks column x, tile row r, the image row pointer
// and the output pointer. All pointers advance by running adds only.
module accel_tile_agen
  import accel_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic [ADDR_W-1:0] i_img_base,
  input  logic [ADDR_W-1:0] i_out_base,
  input  logic [7:0]        i_width,
  input  logic [7:0]        i_height,
  input  logic              i_fetch_step,
  input  logic              i_tile_adv,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_out_addr_c,
  output logic [ADDR_W-1:0] o_out_addr_c2,
  output logic              o_last
);

  logic [7:0]        r_width;
  logic [7:0]        r_height;
  logic [7:0]        r_x;
  logic [7:0]        r_r;
  logic [ADDR_W-1:0] r_row_ptr;    // address of image row r
  logic [ADDR_W-1:0] r_col_ptr;    // address of the tile's top word (row r, column x)
  logic [ADDR_W-1:0] r_fetch_ptr;  // address of the next word to read within the tile
  logic [ADDR_W-1:0] r_out_ptr;    // out_base + 2t

  logic [ADDR_W-1:0] w_width_ext;
  logic [ADDR_W-1:0] w_width_x2;
  logic [ADDR_W-1:0] w_next_row_ptr;
  logic              w_x_wrap;

  assign w_width_ext    = ADDR_W'(r_width);
  assign w_width_x2     = ADDR_W'({r_width, 1'b0});
  assign w_next_row_ptr = r_row_ptr + w_width_x2;
  assign w_x_wrap       = (r_x == r_width - 8'd1);

  assign o_mem_addr    = r_fetch_ptr;
  assign o_out_addr_c  = r_out_ptr;
  assign o_out_addr_c2 = r_out_ptr + ADDR_W'(1);
  assign o_last        = w_x_wrap && (r_r == r_height - 8'd4);

  // Latch geometry on start, then step the fetch pointer per row and move to the next tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width     <= '0;
      r_height    <= '0;
      r_x         <= '0;
      r_r         <= '0;
      r_row_ptr   <= '0;
      r_col_ptr   <= '0;
      r_fetch_ptr <= '0;
      r_out_ptr   <= '0;
    end else if (i_init) begin
      r_width     <= i_width;
      r_height    <= i_height;
      r_x         <= '0;
      r_r         <= '0;
      r_row_ptr   <= i_img_base;
      r_col_ptr   <= i_img_base;
      r_fetch_ptr <= i_img_base;
      r_out_ptr   <= i_out_base;
    end else begin
      if (i_fetch_step) begin
        r_fetch_ptr <= r_fetch_ptr + w_width_ext;
      end
      if (i_tile_adv) begin
        r_out_ptr <= r_out_ptr + ADDR_W'(2);
        if (w_x_wrap) begin
          r_x         <= '0;
          r_r         <= r_r + 8'd2;
          r_row_ptr   <= w_next_row_ptr;
          r_col_ptr   <= w_next_row_ptr;
          r_fetch_ptr <= w_next_row_ptr;
        end else begin
          r_x         <= r_x + 8'd1;
          r_col_ptr   <= r_col_ptr + ADDR_W'(1);
          r_fetch_ptr <= r_col_ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/accel_tile_seq.sv
// Bus-master sequencer: loads the kernel into the accelerator, streams 4x4
// image patches into its B registers and stores the C/C2 results per tile.
module accel_tile_seq
  import accel_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [23:0]       i_cfg_kern0,
  input  logic [23:0]       i_cfg_kern1,
  input  logic [23:0]       i_cfg_kern2,
  input  logic [ADDR_W-1:0] i_cfg_img_base,
  input  logic [ADDR_W-1:0] i_cfg_out_base,
  input  logic [7:0]        i_cfg_width,
  input  logic [7:0]        i_cfg_height,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_acc_sel,
  output logic              o_acc_wr_en,
  output logic [31:0]       o_acc_addr,
  output logic [31:0]       o_acc_wdata,
  input  logic [31:0]       i_acc_rdata,
  output logic              o_out_wr_en,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [31:0]       o_out_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [23:0] r_kern0;
  logic [23:0] r_kern1;
  logic [23:0] r_kern2;
  logic        r_err;

  logic              w_accept;
  logic              w_cfg_bad;
  logic              w_fetch_step;
  logic              w_tile_adv;
  logic              w_last;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [ADDR_W-1:0] w_out_addr_c;
  logic [ADDR_W-1:0] w_out_addr_c2;

  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_cfg_bad = (i_cfg_width == 8'd0) || (i_cfg_height < 8'd4) || i_cfg_height[0];

  accel_tile_agen #(
    .ADDR_W (ADDR_W)
  ) u_agen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_init        (w_accept),
    .i_img_base    (i_cfg_img_base),
    .i_out_base    (i_cfg_out_base),
    .i_width       (i_cfg_width),
    .i_height      (i_cfg_height),
    .i_fetch_step  (w_fetch_step),
    .i_tile_adv    (w_tile_adv),
    .o_mem_addr    (w_fetch_addr),
    .o_out_addr_c  (w_out_addr_c),
    .o_out_addr_c2 (w_out_addr_c2),
    .o_last        (w_last)
  );

  // State and sub-step counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture kernel and error status when a start is accepted; err holds until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kern0 <= '0;
      r_kern1 <= '0;
      r_kern2 <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_kern0 <= i_cfg_kern0;
      r_kern1 <= i_cfg_kern1;
      r_kern2 <= i_cfg_kern2;
      r_err   <= w_cfg_bad;
    end
  end

  // Next-state logic and bus outputs decoded from the current state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fetch_step = 1'b0;
    w_tile_adv   = 1'b0;
    o_mem_rd_en  = 1'b0;
    o_mem_addr   = '0;
    o_acc_sel    = 1'b0;
    o_acc_wr_en  = 1'b0;
    o_acc_addr   = '0;
    o_acc_wdata  = '0;
    o_out_wr_en  = 1'b0;
    o_out_addr   = '0;
    o_out_wdata  = '0;
    o_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (i_start) begin
          w_state_next = w_cfg_bad ? ST_DONE : ST_LDK;
        end
      end

      ST_LDK: begin
        o_acc_sel   = 1'b1;
        o_acc_wr_en = 1'b1;
        case (r_cnt)
          4'd0: begin
            o_acc_addr  = ACC_A0;
            o_acc_wdata = {8'h00, r_kern0};
          end
          4'd1: begin
            o_acc_addr  = ACC_A1;
            o_acc_wdata = {8'h00, r_kern1};
          end
          default: begin
            o_acc_addr  = ACC_A2;
            o_acc_wdata = {8'h00, r_kern2};
          end
        endcase
        if (r_cnt == 4'd2) begin
          w_state_next = ST_GO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end

      ST_GO: begin
        o_acc_sel    = 1'b1;
        o_acc_wr_en  = 1'b1;
        o_acc_addr   = ACC_CTRL;
        o_acc_wdata  = 32'h1;
        w_state_next = ST_FETCH;
        w_cnt_next   = '0;
      end

      ST_FETCH: begin
        // Read of row k overlaps the write of row k-1, whose data arrives this cycle
        if (r_cnt <= 4'd3) begin
          o_mem_rd_en  = 1'b1;
          o_mem_addr   = w_fetch_addr;
          w_fetch_step = 1'b1;
        end
        if (r_cnt >= 4'd1) begin
          o_acc_sel   = 1'b1;
          o_acc_wr_en = 1'b1;
          o_acc_addr  = b_reg_off(r_cnt);
          o_acc_wdata = i_mem_rdata;
        end
        if (r_cnt == 4'd4) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_next = ST_RDC;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end

      ST_RDC: begin
        o_acc_sel    = 1'b1;
        o_acc_addr   = ACC_C;
        o_out_wr_en  = 1'b1;
        o_out_addr   = w_out_addr_c;
        o_out_wdata  = i_acc_rdata;
        w_state_next = ST_RDC2;
      end

      ST_RDC2: begin
        o_acc_sel    = 1'b1;
        o_acc_addr   = ACC_C2;
        o_out_wr_en  = 1'b1;
        o_out_addr   = w_out_addr_c2;
        o_out_wdata  = i_acc_rdata;
        w_tile_adv   = 1'b1;
        w_cnt_next   = '0;
        w_state_next = w_last ? ST_DONE : ST_FETCH;
      end

      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_err  = r_err;

endmodule

// File: doc/accel_tile_seq.md
# accel_tile_seq

Bus-master sequencer that sits directly upstream of the 3x3-kernel matrix accelerator (`ai_accel`) and drives its register port. It loads the kernel once, walks a packed 8-bit image in memory, and writes each 4x4 patch into the accelerator's B registers. For each patch it reads back the normalised 2x2 result word (C) and the variance word (C2), then stores both to an output buffer. It replaces CPU-driven register pokes for whole-image runs.

## Interface

- ADDR_W, 16, word-address width of the image and output memories.
- SETTLE_CYC, 2, wait cycles after the B3 write before C is read; legal range 1..15.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; honoured only in IDLE
- cfg_kern0/1/2  in  24 each  kernel rows; element j in bits [8j+7:8j]
- cfg_img_base  in  ADDR_W  word address of image row 0
- cfg_out_base  in  ADDR_W  word address of the first result
- cfg_width  in  8  image width in 32-bit words (4 pixels per word)
- cfg_height  in  8  image height in rows
- mem_rd_en / mem_addr  out  1 / ADDR_W  image read request
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd_en
- acc_sel / acc_wr_en / acc_addr / acc_wdata  out  1/1/32/32  accelerator register port
- acc_rdata  in  32  accelerator data_out; combinational on acc_addr
- out_wr_en / out_addr / out_wdata  out  1 / ADDR_W / 32  result write port
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky until the next start; set on bad configuration

## Operation

- Accelerator byte offsets: ctrl 0x20, A0 0x28, A1 0x2C, A2 0x30, B0 0x34, B1 0x38, B2 0x3C, B3 0x00, C 0x04, C2 0x08.
- acc_sel is high whenever acc_wr_en is high or a C or C2 read is in progress.
- FSM states:
  - IDLE: on start, latch the configuration. If cfg_width==0, cfg_height<4 or cfg_height is odd, set err and go to DONE. Otherwise go to LDK.
  - LDK, 3 cycles: write A0, A1, A2 with {8'h00, cfg_kernN}.
  - GO, 1 cycle: write ctrl with 32'h1.
  - FETCH, sub-counter k=0..4:
    - For k≤3: issue a memory read at img_base + (r+k)*width + x.
    - For k≥1: write mem_rdata to B(k-1).
  - SETTLE: idle for SETTLE_CYC cycles with acc_wr_en=0.
  - RDC: acc_addr=0x04; out_wr_en=1, out_addr=out_base+2t, out_wdata=acc_rdata.
  - RDC2: acc_addr=0x08; out_wr_en=1, out_addr=out_base+2t+1.
  - After RDC2:
    - Increment x. On x==width, set x=0 and r+=2.
    - If r > height-4, go to DONE; else go to FETCH.
  - DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Tiling: vertical row step is 2; horizontal step is 1 word. Tile count is N = width*((height-4)/2+1), and t counts tiles 0..N-1.
- Address arithmetic is ADDR_W-bit, modulo 2^ADDR_W. Row pointers use running adds (+width per row, +2*width per tile row); no multiplier.
- start while busy is ignored. Configuration inputs are sampled only at start.

## Timing

- Reset: all outputs 0, FSM in IDLE, err=0.
- Reset asserted mid-run aborts immediately. Outputs clear asynchronously, with no partial write completing after the edge.
- Start accepted at cycle 0 → LDK cycles 1–3, GO cycle 4, first FETCH cycle 5.
- Per tile: 5 + SETTLE_CYC + 2 cycles; 9 with the default.
- Run length: done at cycle 5 + N*(7+SETTLE_CYC).
- Bad configuration: done at cycle 1, err=1, no memory or accelerator access.
- mem_rd_en and acc_wr_en overlap during FETCH k=1..3. This is required, not optional.

## Structure

- Shared package (accel_pkg): accelerator register offsets, FSM state enum, default SETTLE_CYC.
- One sub-module, `accel_tile_agen`: holds x, r, t and the row pointer; produces mem_addr and out_addr and flags last tile.

## Test plan

- Kernel center=1 (cfg_kern1=24'h000100, others 0); 4x1-word image with every word 32'h05050505 → one tile; out[base]=0, out[base+1]=0; done at cycle 14.
- Same kernel; image rows 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10 → C and C2 match the golden model; memory reads at base+0..3; B writes land on cycles 6–9.
- width=2, height=6 → 4 tiles; out_addr sequence base..base+7; fetch x/r order (0,0),(1,0),(0,2),(1,2); done at cycle 41.
- cfg_height=5 → err=1, done at cycle 1, no mem_rd_en or acc_wr_en ever asserted; next valid start clears err.
- rst_n pulled low during the RDC of tile 1 → all outputs 0 within the reset edge; a fresh start reruns from tile 0.
- start pulsed while busy → ignored; run completes with unchanged tile count and timing.
